// File: rtl/gtwizard_qpll_reset_seq_if.sv
// Bundle of the QPLL-facing and status signals of the QPLL reset/lock sequencer.
// The sequencer takes the master view; whoever instantiates it (wrapper or test
// environment) takes the slave view.
interface gtwizard_qpll_reset_seq_if;
    logic       QPLLLOCK_IN;
    logic       QPLLREFCLKLOST_IN;
    logic       RESTART_IN;
    logic       QPLLRESET_OUT;
    logic       QPLL_READY_OUT;
    logic       FAIL_OUT;
    logic [3:0] RETRY_COUNT_OUT;
    logic [2:0] STATE_OUT;

    modport master (
        input  QPLLLOCK_IN,
        input  QPLLREFCLKLOST_IN,
        input  RESTART_IN,
        output QPLLRESET_OUT,
        output QPLL_READY_OUT,
        output FAIL_OUT,
        output RETRY_COUNT_OUT,
        output STATE_OUT
    );

    modport slave (
        output QPLLLOCK_IN,
        output QPLLREFCLKLOST_IN,
        output RESTART_IN,
        input  QPLLRESET_OUT,
        input  QPLL_READY_OUT,
        input  FAIL_OUT,
        input  RETRY_COUNT_OUT,
        input  STATE_OUT
    );
endinterface

// File: rtl/gtwizard_qpll_reset_seq.sv
// QPLL common-block reset/lock sequencer: power-up wait, fixed-width QPLLRESET
// pulse, lock qualification with timeout/retry, loss-of-lock recovery and a
// sticky failure flag. Lock and refclk-lost are asynchronous to SYSCLK_IN and
// are only used after a two-flop synchronizer.
module gtwizard_qpll_reset_seq #(
    parameter int unsigned INIT_WAIT_CYCLES    = 50,
    parameter int unsigned RESET_HOLD_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 16,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic                              SYSCLK_IN,
    input  logic                              RESET_N_IN,
    gtwizard_qpll_reset_seq_if.master         qpll
);

    typedef enum logic [2:0] {
        S_INIT_WAIT  = 3'd0,
        S_ASSERT_RST = 3'd1,
        S_WAIT_LOCK  = 3'd2,
        S_READY      = 3'd3,
        S_FAILED     = 3'd4
    } state_t;

    // Terminal counts, pre-sized to the counter widths.
    localparam logic [23:0] INIT_LAST    = 24'(INIT_WAIT_CYCLES - 1);
    localparam logic [23:0] HOLD_LAST    = 24'(RESET_HOLD_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  STABLE_LAST  = 8'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] cnt;
    logic [23:0] cnt_nxt;
    logic [7:0]  stab;
    logic [7:0]  stab_nxt;
    logic [3:0]  retry;
    logic [3:0]  retry_nxt;

    logic        lock_p0;
    logic        lock_p1;
    logic        lost_p0;
    logic        lost_p1;
    logic        lock_s;
    logic        lost_s;

    logic        qpllreset_r;
    logic        ready_r;
    logic        fail_r;

    assign lock_s = lock_p1;
    assign lost_s = lost_p1;

    // Two-flop synchronizers for the asynchronous QPLL status inputs.
    always_ff @(posedge SYSCLK_IN) begin
        if (!RESET_N_IN) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
            lost_p0 <= 1'b0;
            lost_p1 <= 1'b0;
        end else begin
            lock_p0 <= qpll.QPLLLOCK_IN;
            lock_p1 <= lock_p0;
            lost_p0 <= qpll.QPLLREFCLKLOST_IN;
            lost_p1 <= lost_p0;
        end
    end

    // Next-state, counter and retry logic; RESTART_IN overrides every transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 24'd1;
        stab_nxt  = 8'd0;
        retry_nxt = retry;

        case (state)
            S_INIT_WAIT: begin
                if (lost_s) begin
                    cnt_nxt = 24'd0;
                end else if (cnt == INIT_LAST) begin
                    state_nxt = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                stab_nxt = lock_s ? stab + 8'd1 : 8'd0;
                // A lock qualifying on the same cycle as the timeout wins.
                if (lock_s && (stab == STABLE_LAST)) begin
                    state_nxt = S_READY;
                    retry_nxt = 4'd0;
                end else if ((cnt == TIMEOUT_LAST) || lost_s) begin
                    if (retry == RETRY_LIMIT) begin
                        state_nxt = S_FAILED;
                    end else begin
                        state_nxt = S_ASSERT_RST;
                        retry_nxt = (retry == 4'hF) ? retry : retry + 4'd1;
                    end
                end
            end
            S_READY: begin
                cnt_nxt = cnt;
                if (!lock_s || lost_s) begin
                    state_nxt = S_ASSERT_RST;
                end
            end
            S_FAILED: begin
                cnt_nxt = cnt;
            end
            default: begin
                state_nxt = S_INIT_WAIT;
            end
        endcase

        if (qpll.RESTART_IN) begin
            state_nxt = S_ASSERT_RST;
            retry_nxt = 4'd0;
        end

        // Every state entry (including a restart re-entering ASSERT_RST) starts a fresh count.
        if ((state_nxt != state) || qpll.RESTART_IN) begin
            cnt_nxt = 24'd0;
        end
        if (state_nxt != S_WAIT_LOCK) begin
            stab_nxt = 8'd0;
        end
    end

    // State/counter registers and outputs decoded from the next state so they are glitch-free.
    always_ff @(posedge SYSCLK_IN) begin
        if (!RESET_N_IN) begin
            state       <= S_INIT_WAIT;
            cnt         <= 24'd0;
            stab        <= 8'd0;
            retry       <= 4'd0;
            qpllreset_r <= 1'b1;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            stab        <= stab_nxt;
            retry       <= retry_nxt;
            qpllreset_r <= (state_nxt == S_INIT_WAIT) || (state_nxt == S_ASSERT_RST) ||
                           (state_nxt == S_FAILED);
            ready_r     <= (state_nxt == S_READY);
            fail_r      <= (state_nxt == S_FAILED);
        end
    end

    assign qpll.QPLLRESET_OUT   = qpllreset_r;
    assign qpll.QPLL_READY_OUT  = ready_r;
    assign qpll.FAIL_OUT        = fail_r;
    assign qpll.RETRY_COUNT_OUT = retry;
    assign qpll.STATE_OUT       = state;

endmodule

// File: tb/tb_gtwizard_qpll_reset_seq.sv
// Self-checking bench for gtwizard_qpll_reset_seq. Each scenario task drives its
// inputs cycle by cycle, pushes the expected output vector
// {state, qpllreset, ready, fail, retry} into a queue, and pops/compares it
// one time unit after the next rising edge.
module tb_gtwizard_qpll_reset_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] e;
    logic [9:0] act;

    gtwizard_qpll_reset_seq_if qif ();

    gtwizard_qpll_reset_seq #(
        .INIT_WAIT_CYCLES    (4),
        .RESET_HOLD_CYCLES   (3),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (4),
        .MAX_RETRIES         (2)
    ) dut (
        .SYSCLK_IN  (clk),
        .RESET_N_IN (rst_n),
        .qpll       (qif)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ev(input int st, input bit rs, input bit rdy,
                                      input bit fl, input int rt);
        return {3'(st), rs, rdy, fl, 4'(rt)};
    endfunction

    function automatic logic [9:0] observed();
        return {qif.STATE_OUT, qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.FAIL_OUT,
                qif.RETRY_COUNT_OUT};
    endfunction

    task automatic test_reset();
        for (int i = 1; i <= 2; i++) begin
            rst_n = 1'b0;
            qif.QPLLLOCK_IN = 1'b0;
            qif.QPLLREFCLKLOST_IN = 1'b0;
            qif.RESTART_IN = 1'b0;
            exp_q.push_back(ev(0, 1, 0, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b required %b", i, act, e);
            end
        end
    endtask

    task automatic test_bringup();
        for (int i = 1; i <= 20; i++) begin
            rst_n = 1'b1;
            qif.QPLLLOCK_IN = (i >= 12);
            if (i <= 3)       exp_q.push_back(ev(0, 1, 0, 0, 0));
            else if (i <= 6)  exp_q.push_back(ev(1, 1, 0, 0, 0));
            else if (i <= 16) exp_q.push_back(ev(2, 0, 0, 0, 0));
            else              exp_q.push_back(ev(3, 0, 1, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL bringup cyc %0d: got %b required %b", i, act, e);
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int i = 1; i <= 15; i++) begin
            qif.QPLLLOCK_IN = (i >= 8);
            if (i <= 2)       exp_q.push_back(ev(3, 0, 1, 0, 0));
            else if (i <= 5)  exp_q.push_back(ev(1, 1, 0, 0, 0));
            else if (i <= 12) exp_q.push_back(ev(2, 0, 0, 0, 0));
            else              exp_q.push_back(ev(3, 0, 1, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL lock_loss cyc %0d: got %b required %b", i, act, e);
            end
        end
    endtask

    task automatic test_lock_glitch();
        for (int i = 1; i <= 17; i++) begin
            qif.RESTART_IN = (i == 1);
            qif.QPLLLOCK_IN = ((i >= 6) && (i <= 8)) || (i >= 10);
            if (i <= 3)       exp_q.push_back(ev(1, 1, 0, 0, 0));
            else if (i <= 14) exp_q.push_back(ev(2, 0, 0, 0, 0));
            else              exp_q.push_back(ev(3, 0, 1, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL lock_glitch cyc %0d: got %b required %b", i, act, e);
            end
        end
        qif.RESTART_IN = 1'b0;
    endtask

    task automatic test_timeout_fail();
        int a;
        int off;
        for (int i = 1; i <= 75; i++) begin
            qif.RESTART_IN = (i == 1);
            qif.QPLLLOCK_IN = 1'b0;
            if (i <= 69) begin
                a = (i - 1) / 23;
                off = (i - 1) % 23;
                if (off < 3) exp_q.push_back(ev(1, 1, 0, 0, a));
                else         exp_q.push_back(ev(2, 0, 0, 0, a));
            end else begin
                exp_q.push_back(ev(4, 1, 0, 1, 2));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL timeout_fail cyc %0d: got %b required %b", i, act, e);
            end
        end
        qif.RESTART_IN = 1'b0;
    endtask

    task automatic test_recover();
        for (int i = 1; i <= 10; i++) begin
            qif.RESTART_IN = (i == 1);
            qif.QPLLLOCK_IN = (i >= 2);
            if (i <= 3)      exp_q.push_back(ev(1, 1, 0, 0, 0));
            else if (i <= 7) exp_q.push_back(ev(2, 0, 0, 0, 0));
            else             exp_q.push_back(ev(3, 0, 1, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL recover cyc %0d: got %b required %b", i, act, e);
            end
        end
        qif.RESTART_IN = 1'b0;
    endtask

    task automatic test_refclk_lost_and_reset();
        for (int i = 1; i <= 21; i++) begin
            rst_n = !((i == 1) || (i == 17));
            qif.QPLLLOCK_IN = 1'b0;
            qif.QPLLREFCLKLOST_IN = (i >= 2) && (i <= 5);
            if (i <= 10)      exp_q.push_back(ev(0, 1, 0, 0, 0));
            else if (i <= 13) exp_q.push_back(ev(1, 1, 0, 0, 0));
            else if (i <= 16) exp_q.push_back(ev(2, 0, 0, 0, 0));
            else if (i <= 20) exp_q.push_back(ev(0, 1, 0, 0, 0));
            else              exp_q.push_back(ev(1, 1, 0, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            act = observed();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL refclk_reset cyc %0d: got %b required %b", i, act, e);
            end
        end
        rst_n = 1'b1;
        qif.QPLLREFCLKLOST_IN = 1'b0;
    endtask

    initial begin
        qif.QPLLLOCK_IN = 1'b0;
        qif.QPLLREFCLKLOST_IN = 1'b0;
        qif.RESTART_IN = 1'b0;
        #2;
        test_reset();
        test_bringup();
        test_lock_loss();
        test_lock_glitch();
        test_timeout_fail();
        test_recover();
        test_refclk_lost_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
